// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the imem req/valid handshake and
// fills the fetch/decode register, honouring stall, branch/JAL/JALR redirects and fetch_jump squashes.
module rv32i_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [2:0]  pc_next_sel_i,
  input  logic        stall_i,
  input  logic        fetch_jump_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jal_target_i,
  input  logic [31:0] jalr_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_dec_o
);

  localparam logic [2:0] SEL_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] SEL_PC_BRANCH = 3'd1;
  localparam logic [2:0] SEL_PC_JAL    = 3'd2;
  localparam logic [2:0] SEL_PC_JALR   = 3'd3;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] pend_pc;
  logic [31:0] hold_r;
  logic        req_r;

  logic        br;
  logic        jmp;
  logic        redirect;
  logic        seq_sel;
  logic [31:0] target;
  logic [31:0] pc_plus_4;

  // A branch always wins, even over a stall; jumps are only honoured when decode is not stalled.
  always_comb begin
    seq_sel   = (pc_next_sel_i == SEL_PC_PLUS_4);
    br        = (pc_next_sel_i == SEL_PC_BRANCH);
    jmp       = !stall_i && (pc_next_sel_i == SEL_PC_JAL || pc_next_sel_i == SEL_PC_JALR
                             || fetch_jump_i);
    redirect  = br || jmp;
    target    = br                              ? branch_target_i :
                (pc_next_sel_i == SEL_PC_JALR)  ? jalr_target_i   : jal_target_i;
    pc_plus_4 = pc_r + 32'd4;
  end

  assign imem_addr_o = pc_r;
  assign imem_req_o  = req_r;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state         <= BOOT;
      req_r         <= 1'b0;
      pc_r          <= RESET_PC;
      pend_pc       <= '0;
      hold_r        <= '0;
      instruction_o <= NOP_INSTR;
      pc_dec_o      <= RESET_PC;
    end else begin
      unique case (state)
        BOOT: begin
          state <= REQ;
          req_r <= 1'b1;
        end

        REQ: begin
          if (redirect) begin
            instruction_o <= NOP_INSTR;
            if (imem_valid_i) begin
              pc_r <= target;
            end else begin
              // The outstanding request must complete at its old address before moving on.
              pend_pc <= target;
              state   <= DISCARD;
            end
          end else if (stall_i) begin
            if (imem_valid_i) begin
              hold_r <= imem_rdata_i;
              state  <= HOLD;
              req_r  <= 1'b0;
            end
          end else if (imem_valid_i) begin
            instruction_o <= imem_rdata_i;
            pc_dec_o      <= pc_r;
            pc_r          <= pc_plus_4;
          end else begin
            instruction_o <= NOP_INSTR;
          end
        end

        HOLD: begin
          if (redirect) begin
            instruction_o <= NOP_INSTR;
            pc_r          <= target;
            state         <= REQ;
            req_r         <= 1'b1;
          end else if (!stall_i) begin
            instruction_o <= hold_r;
            pc_dec_o      <= pc_r;
            pc_r          <= pc_plus_4;
            state         <= REQ;
            req_r         <= 1'b1;
          end
        end

        DISCARD: begin
          instruction_o <= NOP_INSTR;
          if (redirect) begin
            pend_pc <= target;
          end
          if (imem_valid_i) begin
            pc_r  <= redirect ? target : pend_pc;
            state <= REQ;
          end
        end

        default: begin
          state <= BOOT;
          req_r <= 1'b0;
        end
      endcase
    end
  end

  // Select code 3'd0 is the sequential default; it needs no explicit handling above.
  logic unused_ok;
  assign unused_ok = seq_sel;

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Directed bench for rv32i_fetch_stage: zero-wait and hand-driven imem, stall, redirects,
// PC wrap and reset during DISCARD.
module tb_rv32i_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0]  P4   = 3'd0;
  localparam logic [2:0]  BR   = 3'd1;
  localparam logic [2:0]  JAL  = 3'd2;
  localparam logic [2:0]  JALR = 3'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  sel;
  logic        stall;
  logic        fetch_jump;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction;
  logic [31:0] pc_dec;

  // Memory model: zero-wait mode answers every request with ~addr; manual mode is hand-driven.
  logic        zw;
  logic        man_valid;
  logic [31:0] man_rdata;
  assign imem_valid = zw ? imem_req   : man_valid;
  assign imem_rdata = zw ? ~imem_addr : man_rdata;

  int checks   = 0;
  int failures = 0;

  rv32i_fetch_stage dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .pc_next_sel_i  (sel),
    .stall_i        (stall),
    .fetch_jump_i   (fetch_jump),
    .branch_target_i(branch_target),
    .jal_target_i   (jal_target),
    .jalr_target_i  (jalr_target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .imem_valid_i   (imem_valid),
    .instruction_o  (instruction),
    .pc_dec_o       (pc_dec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr_e,
                            input logic [31:0] pc_dec_e, input logic [31:0] addr_e,
                            input logic req_e);
    check({tag, ".instr"},  instruction, instr_e);
    check({tag, ".pc_dec"}, pc_dec,      pc_dec_e);
    check({tag, ".addr"},   imem_addr,   addr_e);
    check({tag, ".req"},    {31'd0, imem_req}, {31'd0, req_e});
  endtask

  initial begin
    resetn = 1'b0; sel = P4; stall = 1'b0; fetch_jump = 1'b0;
    branch_target = '0; jal_target = '0; jalr_target = '0;
    zw = 1'b1; man_valid = 1'b0; man_rdata = '0;

    // 1: reset then zero-wait streaming
    tick(); tick();
    expect_out("reset", NOP, 32'h0, 32'h0, 1'b0);
    resetn = 1'b1;
    tick(); expect_out("boot",  NOP,          32'h0, 32'h0, 1'b1);
    tick(); expect_out("seq0",  ~32'h0,       32'h0, 32'h4, 1'b1);
    tick(); expect_out("seq4",  ~32'h4,       32'h4, 32'h8, 1'b1);
    tick(); expect_out("seq8",  ~32'h8,       32'h8, 32'hC, 1'b1);
    tick(); expect_out("seqC",  ~32'hC,       32'hC, 32'h10, 1'b1);

    // 2: three-cycle stall with a valid word at 0x10
    stall = 1'b1;
    tick(); expect_out("stall1", ~32'hC, 32'hC, 32'h10, 1'b0);
    tick(); expect_out("stall2", ~32'hC, 32'hC, 32'h10, 1'b0);
    tick(); expect_out("stall3", ~32'hC, 32'hC, 32'h10, 1'b0);
    stall = 1'b0;
    tick(); expect_out("unstall", ~32'h10, 32'h10, 32'h14, 1'b1);
    tick(); expect_out("seq14",   ~32'h14, 32'h14, 32'h18, 1'b1);

    // 3: slow memory, branch into DISCARD, latest target wins, same-cycle target wins
    zw = 1'b0; man_valid = 1'b0;
    sel = BR; branch_target = 32'h200;
    tick(); expect_out("br_disc", NOP, 32'h14, 32'h18, 1'b1);
    sel = JALR; jalr_target = 32'h220;
    tick(); expect_out("disc_ovr", NOP, 32'h14, 32'h18, 1'b1);
    sel = P4; man_valid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick(); expect_out("disc_done", NOP, 32'h14, 32'h220, 1'b1);
    man_valid = 1'b0; sel = BR; branch_target = 32'h260;
    tick(); expect_out("br_disc2", NOP, 32'h14, 32'h220, 1'b1);
    sel = JAL; jal_target = 32'h240; man_valid = 1'b1;
    tick(); expect_out("disc_same", NOP, 32'h14, 32'h240, 1'b1);
    sel = P4; man_valid = 1'b0;
    tick(); expect_out("bubble", NOP, 32'h14, 32'h240, 1'b1);
    man_valid = 1'b1; man_rdata = 32'h00A0_0093;
    tick(); expect_out("accept240", 32'h00A0_0093, 32'h240, 32'h244, 1'b1);

    // 4: fetch_jump squash to jal target, then JALR picks jalr target
    zw = 1'b1; man_valid = 1'b0;
    fetch_jump = 1'b1; jal_target = 32'h80;
    tick(); expect_out("fjump", NOP, 32'h240, 32'h80, 1'b1);
    fetch_jump = 1'b0;
    tick(); expect_out("seq80", ~32'h80, 32'h80, 32'h84, 1'b1);
    sel = JALR; jalr_target = 32'h400;
    tick(); expect_out("jalr", NOP, 32'h80, 32'h400, 1'b1);
    sel = P4;
    tick(); expect_out("seq400", ~32'h400, 32'h400, 32'h404, 1'b1);

    // 5: branch beats stall, in REQ and in HOLD; JAL suppressed by stall
    sel = BR; stall = 1'b1; branch_target = 32'h300;
    tick(); expect_out("br_stall", NOP, 32'h400, 32'h300, 1'b1);
    sel = P4;
    tick(); expect_out("hold", NOP, 32'h400, 32'h300, 1'b0);
    sel = BR; branch_target = 32'h500;
    tick(); expect_out("br_hold", NOP, 32'h400, 32'h500, 1'b1);
    sel = P4; stall = 1'b0;
    tick(); expect_out("seq500", ~32'h500, 32'h500, 32'h504, 1'b1);
    sel = JAL; stall = 1'b1; jal_target = 32'h80;
    tick(); expect_out("jal_stall", ~32'h500, 32'h500, 32'h504, 1'b0);
    sel = P4; stall = 1'b0;
    tick(); expect_out("seq504", ~32'h504, 32'h504, 32'h508, 1'b1);

    // 6: PC wrap, then reset in the middle of DISCARD with a late valid
    sel = BR; branch_target = 32'hFFFF_FFFC;
    tick(); expect_out("br_top", NOP, 32'h504, 32'hFFFF_FFFC, 1'b1);
    sel = P4;
    tick(); expect_out("wrap", 32'h0000_0003, 32'hFFFF_FFFC, 32'h0, 1'b1);
    sel = BR; branch_target = 32'h600;
    tick(); expect_out("br600", NOP, 32'hFFFF_FFFC, 32'h600, 1'b1);
    zw = 1'b0; man_valid = 1'b0; branch_target = 32'h700;
    tick(); expect_out("disc600", NOP, 32'hFFFF_FFFC, 32'h600, 1'b1);
    sel = P4; resetn = 1'b0;
    tick(); expect_out("rst_disc", NOP, 32'h0, 32'h0, 1'b0);
    man_valid = 1'b1; man_rdata = 32'h0000_0BAD;
    tick(); expect_out("rst_late", NOP, 32'h0, 32'h0, 1'b0);
    resetn = 1'b1;
    tick(); expect_out("reboot", NOP, 32'h0, 32'h0, 1'b1);
    man_valid = 1'b0;
    tick(); expect_out("reboot_bub", NOP, 32'h0, 32'h0, 1'b1);
    zw = 1'b1;
    tick(); expect_out("reboot_seq", ~32'h0, 32'h0, 32'h4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
